jk_counter_sync: RTL and testbench

- Parametrised synchronous up/down modulo counter built from JK flip-flop cells. Each bit is a JK stage with next state Q+ = (J & ~Q) | (~K & Q).
- Generalises the single JK flip-flop to a WIDTH-bit register with:
  - programmable modulus
  - parallel load
  - synchronous clear
  - count enable and direction
  - registered carry/borrow pulse
- Used as the counter primitive in the FF_sync exercise set, and feeds dividers and sequencers downstream.

---
 rtl/jk_counter_sync.sv | 97 +++++++++
 tb/tb_jk_counter_sync.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/jk_counter_sync.sv
// Synchronous up/down modulo counter built from per-bit JK stages.
// Ports:
//   CK  - clock, all state changes on the rising edge
//   RB  - asynchronous active-low reset (Q <= RST_VAL, CO <= 0)
//   CLR - synchronous clear (highest priority)
//   LD  - synchronous parallel load of D, clamped to MODULUS-1
//   D   - load value
//   EN  - count enable
//   UP  - count direction, 1 = up, 0 = down
//   Q   - registered count
//   TC  - terminal count, combinational from Q and UP
//   CO  - registered one-cycle pulse after a wrapping count edge
module jk_counter_sync #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             CK,
  input  logic             RB,
  input  logic             CLR,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CO
);

  localparam int unsigned     W1    = WIDTH + 1;
  // Modulus held at WIDTH+1 bits so MODULUS = 2^WIDTH does not alias to 0.
  localparam logic [WIDTH:0]   MOD_W = W1'(MODULUS);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             co_q, co_d;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j, k;
  logic [WIDTH:0]   q_ext, inc, dec;

  // Next-count function, then per-bit J/K derived from it.
  always_comb begin
    q_ext = {1'b0, q_q};
    inc   = q_ext + W1'(1);
    dec   = q_ext - W1'(1);
    nxt   = q_q;
    co_d  = 1'b0;

    if (CLR) begin
      nxt = '0;
    end else if (LD) begin
      nxt = ({1'b0, D} < MOD_W) ? D : LAST;
    end else if (EN) begin
      if (q_ext >= MOD_W) begin
        // Out-of-range state recovers to zero on the next count edge.
        nxt = '0;
      end else if (UP) begin
        if (inc == MOD_W) begin
          nxt  = '0;
          co_d = 1'b1;
        end else begin
          nxt = inc[WIDTH-1:0];
        end
      end else begin
        // Borrow out of the extended bit marks the 0 -> MODULUS-1 wrap.
        if (dec[WIDTH]) begin
          nxt  = LAST;
          co_d = 1'b1;
        end else begin
          nxt = dec[WIDTH-1:0];
        end
      end
    end

    // J sets, K resets; J and K are never both asserted for a bit that holds.
    j   = nxt & ~q_q;
    k   = ~nxt & q_q;
    q_d = (j & ~q_q) | (~k & q_q);
  end

  // State register.
  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      q_q  <= RST_Q;
      co_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      co_q <= co_d;
    end
  end

  assign Q  = q_q;
  assign CO = co_q;
  assign TC = UP ? (q_q == LAST) : (q_q == '0);

endmodule

// File: tb/tb_jk_counter_sync.sv
// Bench for jk_counter_sync: a decimal (MODULUS=10) and a full-range
// (MODULUS=16) instance driven by shared stimulus, each tracked by a modulo model.
module tb_jk_counter_sync;

  logic       CK;
  logic       RB;
  logic       CLR;
  logic       LD;
  logic [3:0] D;
  logic       EN;
  logic       UP;
  logic [3:0] qa, qb;
  logic       tca, tcb, coa, cob;

  int checks   = 0;
  int failures = 0;

  int ma_q = 0, ma_co = 0;
  int mb_q = 0, mb_co = 0;

  jk_counter_sync #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) u_a (
    .CK(CK), .RB(RB), .CLR(CLR), .LD(LD), .D(D), .EN(EN), .UP(UP),
    .Q(qa), .TC(tca), .CO(coa)
  );

  jk_counter_sync #(.WIDTH(4), .MODULUS(16), .RST_VAL(0)) u_b (
    .CK(CK), .RB(RB), .CLR(CLR), .LD(LD), .D(D), .EN(EN), .UP(UP),
    .Q(qb), .TC(tcb), .CO(cob)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_q(input int m, input int q);
    if (CLR) return 0;
    if (LD) return (int'(D) < m) ? int'(D) : m - 1;
    if (EN) begin
      if (q >= m) return 0;
      if (UP) return (q + 1) % m;
      return (q + m - 1) % m;
    end
    return q;
  endfunction

  function automatic int next_co(input int m, input int q);
    if (CLR || LD || !EN || q >= m) return 0;
    if (UP) return (q == m - 1) ? 1 : 0;
    return (q == 0) ? 1 : 0;
  endfunction

  // Reference model: modulo arithmetic on integers.
  always @(posedge CK or negedge RB) begin
    if (!RB) begin
      ma_q <= 0; ma_co <= 0; mb_q <= 0; mb_co <= 0;
    end else begin
      ma_q  <= next_q(10, ma_q);
      ma_co <= next_co(10, ma_q);
      mb_q  <= next_q(16, mb_q);
      mb_co <= next_co(16, mb_q);
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge CK) begin
    #3;
    check("a_q",  32'(qa),  32'(ma_q));
    check("a_co", 32'(coa), 32'(ma_co));
    check("a_tc", 32'(tca), UP ? 32'(ma_q == 9) : 32'(ma_q == 0));
    check("b_q",  32'(qb),  32'(mb_q));
    check("b_co", 32'(cob), 32'(mb_co));
    check("b_tc", 32'(tcb), UP ? 32'(mb_q == 15) : 32'(mb_q == 0));
  end

  // Drive inputs, then wait through one rising edge to the next falling edge.
  task automatic apply(input logic clr, input logic ld, input logic [3:0] d,
                       input logic en, input logic up);
    CLR = clr; LD = ld; D = d; EN = en; UP = up;
    @(negedge CK);
  endtask

  int exp_q;
  int n_coa, n_cob;

  initial begin
    RB = 1'b0; CLR = 1'b0; LD = 1'b0; D = '0; EN = 1'b0; UP = 1'b1;
    repeat (2) @(negedge CK);
    check("rst_q", 32'(qa), 32'd0);
    check("rst_co", 32'(coa), 32'd0);
    RB = 1'b1;

    // Hold with EN=0
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 4'd0, 0, 1);
      check("hold_q", 32'(qa), 32'd0);
    end

    // Asynchronous reset mid-cycle from Q=7
    apply(0, 1, 4'd7, 0, 1);
    check("ld7_q", 32'(qa), 32'd7);
    #2 RB = 1'b0;
    #1;
    check("async_rst_q", 32'(qa), 32'd0);
    check("async_rst_co", 32'(coa), 32'd0);
    @(negedge CK);
    check("rst_held_q", 32'(qa), 32'd0);
    RB = 1'b1;

    // Up count through the 9 -> 0 wrap
    for (int i = 1; i <= 12; i++) begin
      apply(0, 0, 4'd0, 1, 1);
      exp_q = i % 10;
      check("up_q", 32'(qa), 32'(exp_q));
      check("up_co", 32'(coa), 32'(i == 10));
      check("up_tc", 32'(tca), 32'(exp_q == 9));
    end

    // Down count through the 0 -> 9 wrap
    apply(0, 1, 4'd1, 0, 0);
    check("ld1_q", 32'(qa), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      apply(0, 0, 4'd0, 1, 0);
      exp_q = (i == 1) ? 0 : 11 - i;
      check("dn_q", 32'(qa), 32'(exp_q));
      check("dn_co", 32'(coa), 32'(i == 2));
      check("dn_tc", 32'(tca), 32'(exp_q == 0));
    end

    // Load and clamp
    apply(0, 1, 4'd6, 0, 1);
    check("ld6_q", 32'(qa), 32'd6);
    apply(0, 1, 4'd13, 0, 1);
    check("clamp_q", 32'(qa), 32'd9);
    check("noclamp_b_q", 32'(qb), 32'd13);
    apply(0, 1, 4'd3, 1, 1);
    check("ld_en_q", 32'(qa), 32'd3);
    check("ld_en_co", 32'(coa), 32'd0);

    // Clear beats load and enable
    apply(0, 1, 4'd8, 0, 1);
    check("ld8_q", 32'(qa), 32'd8);
    apply(1, 1, 4'd5, 1, 1);
    check("clr_pri_q", 32'(qa), 32'd0);
    check("clr_pri_co", 32'(coa), 32'd0);

    // Full-range instance wraps in both directions
    apply(0, 1, 4'd15, 0, 1);
    check("b_ld15", 32'(qb), 32'd15);
    check("b_tc15", 32'(tcb), 32'd1);
    apply(0, 0, 4'd0, 1, 1);
    check("b_upwrap_q", 32'(qb), 32'd0);
    check("b_upwrap_co", 32'(cob), 32'd1);
    apply(0, 0, 4'd0, 1, 0);
    check("b_dnwrap_q", 32'(qb), 32'd15);
    check("b_dnwrap_co", 32'(cob), 32'd1);

    // 32 continuous up edges from zero
    apply(1, 0, 4'd0, 0, 1);
    n_coa = 0;
    n_cob = 0;
    for (int i = 0; i < 32; i++) begin
      apply(0, 0, 4'd0, 1, 1);
      if (coa) n_coa++;
      if (cob) n_cob++;
    end
    check("b_co_count32", 32'(n_cob), 32'd2);
    check("a_co_count32", 32'(n_coa), 32'd3);
    check("a_q_after32", 32'(qa), 32'd2);
    check("b_q_after32", 32'(qb), 32'd0);

    apply(0, 0, 4'd0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
